// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command codes, controller states and width helper for the LCD window controller
package lcd_pkg;

    typedef enum logic [3:0] {
        CMD_REFRESH  = 4'd0,
        CMD_LOAD     = 4'd1,
        CMD_ZOOM_IN  = 4'd2,
        CMD_ZOOM_OUT = 4'd3,
        CMD_RIGHT    = 4'd4,
        CMD_LEFT     = 4'd5,
        CMD_UP       = 4'd6,
        CMD_DOWN     = 4'd7,
        CMD_HMIR     = 4'd8,
        CMD_VMIR     = 4'd9
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        OUT
    } state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/lcd_addr_gen.sv
// lcd_addr_gen: maps an output beat to the raster index of the pixel to display
module lcd_addr_gen
    import lcd_pkg::*;
#(
    parameter int IMG = 8,
    parameter int WIN = 4,
    localparam int OW = clog2_min1(IMG),
    localparam int BW = clog2_min1(WIN * WIN),
    localparam int AW = clog2_min1(IMG * IMG)
) (
    input  logic          i_mag,
    input  logic [OW-1:0] i_ox,
    input  logic [OW-1:0] i_oy,
    input  logic          i_hmir,
    input  logic          i_vmir,
    input  logic [BW-1:0] i_beat,
    output logic [AW-1:0] o_idx
);

    localparam int S = IMG / WIN;

    int w_r, w_c, w_rm, w_cm, w_idx;

    // Beat -> window row/col, mirror within the window, then magnified crop or decimated full view
    always_comb begin
        w_r   = int'(i_beat) / WIN;
        w_c   = int'(i_beat) % WIN;
        w_rm  = i_vmir ? WIN - 1 - w_r : w_r;
        w_cm  = i_hmir ? WIN - 1 - w_c : w_c;
        w_idx = i_mag ? (int'(i_oy) + w_rm) * IMG + int'(i_ox) + w_cm
                      : w_rm * S * IMG + w_cm * S;
        o_idx = w_idx[AW-1:0];
    end

endmodule

// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: loads an IMG x IMG image and streams a WIN x WIN zoomed/panned/mirrored window
module lcd_win_ctrl
    import lcd_pkg::*;
#(
    parameter int DW  = 8,
    parameter int IMG = 8,
    parameter int WIN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N  = IMG * IMG;
    localparam int W  = WIN * WIN;
    localparam int OW = clog2_min1(IMG);
    localparam int BW = clog2_min1(W);
    localparam int AW = clog2_min1(N);
    localparam logic [OW-1:0] OMAX  = OW'(IMG - WIN);
    localparam logic [OW-1:0] OCTR  = OW'((IMG - WIN) / 2);
    localparam logic [BW-1:0] BLAST = BW'(W - 1);
    localparam logic [AW-1:0] ALAST = AW'(N - 1);

    state_e        r_state;
    logic [DW-1:0] r_mem [N];
    logic [DW-1:0] r_dout;
    logic          r_valid;
    logic          r_busy;
    logic          r_mag;
    logic          r_hmir;
    logic          r_vmir;
    logic [OW-1:0] r_ox;
    logic [OW-1:0] r_oy;
    logic [BW-1:0] r_beat;
    logic [AW-1:0] r_lcnt;
    logic [AW-1:0] w_idx;

    assign dataout      = r_dout;
    assign output_valid = r_valid;
    assign busy         = r_busy;

    lcd_addr_gen #(
        .IMG (IMG),
        .WIN (WIN)
    ) u_addr (
        .i_mag  (r_mag),
        .i_ox   (r_ox),
        .i_oy   (r_oy),
        .i_hmir (r_hmir),
        .i_vmir (r_vmir),
        .i_beat (r_beat),
        .o_idx  (w_idx)
    );

    // Command decode, pixel load and window streaming; busy/valid drop together one edge after the last beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_mag   <= 1'b0;
            r_hmir  <= 1'b0;
            r_vmir  <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_beat  <= '0;
            r_lcnt  <= '0;
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    if (cmd_valid && !r_busy && cmd <= CMD_VMIR) begin
                        r_busy  <= 1'b1;
                        r_beat  <= '0;
                        r_lcnt  <= '0;
                        r_state <= (cmd == CMD_LOAD) ? LOAD : OUT;
                        case (cmd)
                            CMD_LOAD: begin
                                r_mag  <= 1'b0;
                                r_hmir <= 1'b0;
                                r_vmir <= 1'b0;
                                r_ox   <= '0;
                                r_oy   <= '0;
                            end
                            CMD_ZOOM_IN: begin
                                r_mag <= 1'b1;
                                r_ox  <= OCTR;
                                r_oy  <= OCTR;
                            end
                            CMD_ZOOM_OUT: begin
                                r_mag <= 1'b0;
                                r_ox  <= '0;
                                r_oy  <= '0;
                            end
                            CMD_RIGHT: if (r_mag && r_ox != OMAX) r_ox <= r_ox + 1'b1;
                            CMD_LEFT:  if (r_mag && r_ox != '0)   r_ox <= r_ox - 1'b1;
                            CMD_DOWN:  if (r_mag && r_oy != OMAX) r_oy <= r_oy + 1'b1;
                            CMD_UP:    if (r_mag && r_oy != '0)   r_oy <= r_oy - 1'b1;
                            CMD_HMIR:  r_hmir <= !r_hmir;
                            CMD_VMIR:  r_vmir <= !r_vmir;
                            default: ;
                        endcase
                    end
                end
                LOAD: begin
                    r_mem[r_lcnt] <= datain;
                    r_lcnt        <= r_lcnt + 1'b1;
                    if (r_lcnt == ALAST) r_state <= OUT;
                end
                OUT: begin
                    r_dout  <= r_mem[w_idx];
                    r_valid <= 1'b1;
                    r_beat  <= r_beat + 1'b1;
                    if (r_beat == BLAST) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// tb_lcd_win_ctrl: scoreboard bench for the LCD window controller at IMG=8, WIN=4
module tb_lcd_win_ctrl;

    localparam int DW  = 8;
    localparam int IMG = 8;
    localparam int WIN = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int bcyc = 0;
    logic prev_v = 1'b0;
    int e[16];

    always #5 clk = ~clk;

    lcd_win_ctrl #(
        .DW  (DW),
        .IMG (IMG),
        .WIN (WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pop and compare every beat, check busy tracks output_valid, count busy cycles
    always @(negedge clk) begin
        if (output_valid) begin
            if (exp_q.size() == 0) chk("unexpected_beat", int'(dataout), -1);
            else chk("beat", int'(dataout), exp_q.pop_front());
            chk("busy_with_valid", int'(busy), 1);
        end else if (prev_v) begin
            chk("busy_fall", int'(busy), 0);
        end
        prev_v = output_valid;
        if (busy) bcyc++;
    end

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        chk("timeout_pending", exp_q.size() + int'(busy), 0);
        exp_q.delete();
    endtask

    task automatic run(input logic [3:0] c, input int ex[16], input int cyc);
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        bcyc = 0;
        foreach (ex[i]) exp_q.push_back(ex[i]);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done();
        if (cyc > 0) chk("busy_cycles", bcyc, cyc);
    endtask

    task automatic load(input int abort_at, input int ex[16]);
        @(negedge clk);
        cmd = 4'd1;
        cmd_valid = 1'b1;
        bcyc = 0;
        for (int i = 0; i < IMG * IMG; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (i == 10) begin
                cmd = 4'd2;
                cmd_valid = 1'b1;
            end
            datain = DW'(i);
            if (i == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                chk("abort_busy", int'(busy), 0);
                chk("abort_valid", int'(output_valid), 0);
                reset = 1'b1;
                datain = '0;
                return;
            end
        end
        foreach (ex[i]) exp_q.push_back(ex[i]);
        wait_done();
        chk("load_busy_cycles", bcyc, 81);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dataout", int'(dataout), 0);
        chk("rst_valid", int'(output_valid), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;

        e = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38, 48, 50, 52, 54};
        load(-1, e);
        run(4'd0, e, 17);

        e = '{18, 19, 20, 21, 26, 27, 28, 29, 34, 35, 36, 37, 42, 43, 44, 45};
        run(4'd2, e, 17);
        e = '{19, 20, 21, 22, 27, 28, 29, 30, 35, 36, 37, 38, 43, 44, 45, 46};
        run(4'd4, e, 0);
        e = '{20, 21, 22, 23, 28, 29, 30, 31, 36, 37, 38, 39, 44, 45, 46, 47};
        run(4'd4, e, 0);
        run(4'd4, e, 0);
        e = '{12, 13, 14, 15, 20, 21, 22, 23, 28, 29, 30, 31, 36, 37, 38, 39};
        run(4'd6, e, 0);

        e = '{18, 19, 20, 21, 26, 27, 28, 29, 34, 35, 36, 37, 42, 43, 44, 45};
        run(4'd2, e, 0);
        e = '{21, 20, 19, 18, 29, 28, 27, 26, 37, 36, 35, 34, 45, 44, 43, 42};
        run(4'd8, e, 0);
        e = '{45, 44, 43, 42, 37, 36, 35, 34, 29, 28, 27, 26, 21, 20, 19, 18};
        run(4'd9, e, 0);
        e = '{54, 52, 50, 48, 38, 36, 34, 32, 22, 20, 18, 16, 6, 4, 2, 0};
        run(4'd3, e, 0);
        run(4'd4, e, 0);

        @(negedge clk);
        cmd = 4'd15;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ignored_cmd_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("ignored_cmd_busy_later", int'(busy), 0);

        load(30, e);
        repeat (2) @(negedge clk);
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run(4'd0, e, 17);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
